// File: rtl/adder_pipe_pkg.sv
// Shared types and helpers for the pipelined chunked adder/subtractor.
package adder_pipe_pkg;

    // Per-stage control bundle: occupancy bit and carry out of that stage's chunk.
    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    localparam int unsigned MAX_STAGES = 64;

    function automatic int unsigned stages(input int unsigned width, input int unsigned chunk);
        return (chunk == 0) ? 0 : width / chunk;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned chunk);
        return (chunk != 0) && (width != 0) && ((width % chunk) == 0) &&
               (stages(width, chunk) <= MAX_STAGES);
    endfunction

    localparam bit DEFAULT_CFG_OK = cfg_ok(32, 8);

endpackage

// File: rtl/adder_chunk.sv
// Combinational CHUNK-bit adder slice with carry in/out.
module adder_chunk #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/adder_pipe_nbit.sv
// Pipelined WIDTH-bit adder/subtractor, one CHUNK per stage, valid/ready on both sides.
// Define ADDER_PIPE_OVF_EN to add the signed-overflow output and its sign flops.
module adder_pipe_nbit
    import adder_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef ADDER_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned STAGES = stages(WIDTH, CHUNK);

    if (!cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("adder_pipe_nbit: WIDTH must be a non-zero multiple of CHUNK");
    end

    logic [WIDTH-1:0]  op2e;
    logic              c0;
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] adv;

    assign op2e = sub ? ~op2 : op2;
    assign c0   = cin ^ sub;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * CHUNK;
        // Operand-2 chunks k.. are still pending when a beat enters stage k.
        localparam int unsigned BW = WIDTH - LO;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] a_d;
        logic [WIDTH-1:0] a_q;
        logic [BW-1:0]    b_in;
        logic             c_in;
        logic             v_in;
        logic             co;
        logic [CHUNK-1:0] s;
        stage_ctl_t       ctl_q;

        if (k == 0) begin : g_head
            assign a_in = op1;
            assign b_in = op2e;
            assign c_in = c0;
            assign v_in = in_valid;
        end else begin : g_body
            assign a_in = g_stage[k-1].a_q;
            assign b_in = g_stage[k-1].g_fwd.b_q;
            assign c_in = g_stage[k-1].ctl_q.carry;
            assign v_in = g_stage[k-1].ctl_q.valid;
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a  (a_in[LO +: CHUNK]),
            .b  (b_in[CHUNK-1:0]),
            .ci (c_in),
            .s  (s),
            .co (co)
        );

        // a_q holds finished sum chunks 0..k below and untouched op1 chunks above.
        always_comb begin
            a_d              = a_in;
            a_d[LO +: CHUNK] = s;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctl_q <= '0;
                a_q   <= '0;
            end else if (adv[k]) begin
                ctl_q.valid <= v_in;
                if (v_in) begin
                    ctl_q.carry <= co;
                    a_q         <= a_d;
                end
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [BW-CHUNK-1:0] b_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    b_q <= '0;
                end else if (adv[k] && v_in) begin
                    b_q <= b_in[BW-1:CHUNK];
                end
            end
        end
`ifdef ADDER_PIPE_OVF_EN
        else begin : g_sign
            logic s1_q;
            logic s2_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_q <= 1'b0;
                    s2_q <= 1'b0;
                end else if (adv[k] && v_in) begin
                    s1_q <= a_in[WIDTH-1];
                    s2_q <= b_in[BW-1];
                end
            end
        end
`endif

        assign vld[k] = ctl_q.valid;
        // Advance when any stage from here to the tail has a hole, or the tail drains.
        assign adv[k] = out_ready | ~(&vld[STAGES-1:k]);
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign sum       = g_stage[STAGES-1].a_q;
    assign cout      = g_stage[STAGES-1].ctl_q.carry;

`ifdef ADDER_PIPE_OVF_EN
    assign ovf = (g_stage[STAGES-1].g_sign.s1_q == g_stage[STAGES-1].g_sign.s2_q) &
                 (sum[WIDTH-1] != g_stage[STAGES-1].g_sign.s1_q);
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// Self-checking bench: three configurations (32/8, 16/4, 8/8) driven from shared stimulus.
module tb_adder_pipe_nbit;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
    } beat_t;

    typedef struct {
        int          d;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, cin, sub, out_ready;
    logic [31:0] op1, op2;
    logic        ir32, ov32, co32, ir16, ov16, co16, ir8, ov8, co8;
    logic [31:0] s32;
    logic [15:0] s16;
    logic [7:0]  s8;
    logic        ir [3];
    logic        ovl [3];
    logic        co [3];
    logic        of [3];
    logic [31:0] sm [3];
`ifdef ADDER_PIPE_OVF_EN
    logic        of32, of16, of8;
`endif

    int    errors = 0;
    int    checks = 0;
    beat_t stim[$];
    exp_t  expq[$];
    res_t  res32[$];

    always #5 clk = ~clk;

    adder_pipe_nbit #(.WIDTH(32), .CHUNK(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir32), .op1(op1), .op2(op2),
        .cin(cin), .sub(sub), .out_valid(ov32), .out_ready(out_ready), .sum(s32), .cout(co32)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(of32)
`endif
    );

    adder_pipe_nbit #(.WIDTH(16), .CHUNK(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16), .op1(op1[15:0]),
        .op2(op2[15:0]), .cin(cin), .sub(sub), .out_valid(ov16), .out_ready(out_ready),
        .sum(s16), .cout(co16)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(of16)
`endif
    );

    adder_pipe_nbit #(.WIDTH(8), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir8), .op1(op1[7:0]),
        .op2(op2[7:0]), .cin(cin), .sub(sub), .out_valid(ov8), .out_ready(out_ready),
        .sum(s8), .cout(co8)
`ifdef ADDER_PIPE_OVF_EN
        , .ovf(of8)
`endif
    );

    always_comb begin
        ir[0] = ir32; ovl[0] = ov32; co[0] = co32; sm[0] = s32;
        ir[1] = ir16; ovl[1] = ov16; co[1] = co16; sm[1] = {16'b0, s16};
        ir[2] = ir8;  ovl[2] = ov8;  co[2] = co8;  sm[2] = {24'b0, s8};
`ifdef ADDER_PIPE_OVF_EN
        of[0] = of32; of[1] = of16; of[2] = of8;
`else
        of[0] = 1'b0; of[1] = 1'b0; of[2] = 1'b0;
`endif
    end

    function automatic int wd(input int d);
        return (d == 0) ? 32 : ((d == 1) ? 16 : 8);
    endfunction

    function automatic int st(input int d);
        return (d == 2) ? 1 : 4;
    endfunction

    // Reference: plain (W+1)-bit arithmetic on the masked operands.
    function automatic exp_t model(input int d, input beat_t b, input int cyc);
        int          w;
        logic [63:0] m, aa, bb, r;
        exp_t        e;
        w  = wd(d);
        m  = (64'd1 << w) - 64'd1;
        aa = {32'b0, b.a} & m;
        bb = (b.s ? ~{32'b0, b.b} : {32'b0, b.b}) & m;
        r  = aa + bb + {63'b0, b.c ^ b.s};
        e.d    = d;
        e.sum  = 32'(r & m);
        e.cout = r[w];
        e.ovf  = (aa[w-1] == bb[w-1]) && (r[w-1] != aa[w-1]);
        e.cyc  = cyc;
        return e;
    endfunction

    task automatic run(input int rdy_pct, input bit chk_lat, input string name);
        int          idx, cyc, qi;
        int          occ [3];
        bit          hold [3];
        logic [31:0] hsum [3];
        bit          done, exp_ir;
        beat_t       cur;
        exp_t        e;
        idx = 0; cyc = 0; done = 0;
        for (int d = 0; d < 3; d++) begin
            occ[d] = 0; hold[d] = 0; hsum[d] = '0;
        end
        while (!done) begin
            @(negedge clk);
            out_ready = ($urandom_range(0, 99) < rdy_pct);
            if (idx < stim.size()) begin
                cur = stim[idx];
                in_valid = 1'b1;
            end else begin
                cur.a = $urandom; cur.b = $urandom; cur.c = 1'b0; cur.s = 1'b0;
                in_valid = 1'b0;
            end
            op1 = cur.a; op2 = cur.b; cin = cur.c; sub = cur.s;
            #1;
            for (int d = 0; d < 3; d++) begin
                exp_ir = !(occ[d] == st(d) && !out_ready);
                checks++;
                if (ir[d] !== exp_ir) begin
                    errors++;
                    $display("FAIL %s in_ready dut%0d cyc %0d: got %b want %b",
                             name, d, cyc, ir[d], exp_ir);
                end
                if (hold[d]) begin
                    checks++;
                    if (ovl[d] !== 1'b1 || sm[d] !== hsum[d]) begin
                        errors++;
                        $display("FAIL %s hold dut%0d cyc %0d: got v=%b sum=%h want v=1 sum=%h",
                                 name, d, cyc, ovl[d], sm[d], hsum[d]);
                    end
                end
                hold[d] = ovl[d] && !out_ready;
                hsum[d] = sm[d];
                if (ovl[d] && out_ready) begin
                    qi = -1;
                    for (int j = 0; j < expq.size(); j++)
                        if (qi < 0 && expq[j].d == d) qi = j;
                    checks++;
                    if (qi < 0) begin
                        errors++;
                        $display("FAIL %s spurious dut%0d cyc %0d: got sum=%h want no beat",
                                 name, d, cyc, sm[d]);
                    end else begin
                        e = expq[qi];
                        expq.delete(qi);
                        if (sm[d] !== e.sum || co[d] !== e.cout) begin
                            errors++;
                            $display("FAIL %s result dut%0d: got %b/%h want %b/%h",
                                     name, d, co[d], sm[d], e.cout, e.sum);
                        end
`ifdef ADDER_PIPE_OVF_EN
                        checks++;
                        if (of[d] !== e.ovf) begin
                            errors++;
                            $display("FAIL %s ovf dut%0d: got %b want %b", name, d, of[d], e.ovf);
                        end
`endif
                        if (chk_lat) begin
                            checks++;
                            if (cyc - e.cyc != st(d)) begin
                                errors++;
                                $display("FAIL %s latency dut%0d: got %0d want %0d",
                                         name, d, cyc - e.cyc, st(d));
                            end
                        end
                        if (d == 0) res32.push_back('{sm[0], co[0], of[0]});
                        occ[d]--;
                    end
                end
                if (in_valid && ir[d]) begin
                    expq.push_back(model(d, cur, cyc));
                    occ[d]++;
                end
            end
            if (in_valid && ir[0]) idx++;
            cyc++;
            done = (idx >= stim.size()) && (expq.size() == 0);
            if (!done && cyc >= 4000) begin
                errors++; checks++;
                $display("FAIL %s timeout: got %0d beats pending want 0", name, expq.size());
                done = 1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        stim.delete();
        expq.delete();
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic c, input logic s);
        stim.push_back('{a, b, c, s});
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op1 = '0; op2 = '0; cin = 1'b0; sub = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ovl[d] !== 1'b0 || sm[d] !== '0 || co[d] !== 1'b0) begin
                errors++;
                $display("FAIL reset_state dut%0d: got v=%b sum=%h c=%b want 0/0/0",
                         d, ovl[d], sm[d], co[d]);
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (ir32 !== 1'b1 || ir16 !== 1'b1 || ir8 !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b%b%b want 111", ir32, ir16, ir8);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            in_valid = 1'b1; op1 = $urandom; op2 = $urandom;
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++;
        if (ov32 !== 1'b1 || ov8 !== 1'b1) begin
            errors++;
            $display("FAIL mid_fill: got v32=%b v8=%b want 1/1", ov32, ov8);
        end
        #1 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ovl[d] !== 1'b0 || sm[d] !== '0) begin
                errors++;
                $display("FAIL mid_reset dut%0d: got v=%b sum=%h want 0/0", d, ovl[d], sm[d]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if (ov32 !== 1'b0 || ov16 !== 1'b0 || ov8 !== 1'b0) begin
                errors++;
                $display("FAIL stale_beat cyc %0d: got %b%b%b want 000", c, ov32, ov16, ov8);
            end
        end
    endtask

    task automatic test_walking;
        logic [31:0] es;
        res32.delete();
        for (int i = 0; i < 32; i++)
            for (int c = 0; c < 2; c++) push(32'd1 << i, 32'd1 << i, c[0], 1'b0);
        run(100, 1'b1, "walk");
        checks++;
        if (res32.size() != 64) begin
            errors++;
            $display("FAIL walk_count: got %0d want 64", res32.size());
        end else begin
            for (int i = 0; i < 32; i++)
                for (int c = 0; c < 2; c++) begin
                    es = 32'(64'd2 << i) + 32'(c);
                    checks++;
                    if (res32[2*i+c].sum !== es || res32[2*i+c].cout !== (i == 31)) begin
                        errors++;
                        $display("FAIL walk i=%0d cin=%0d: got %b/%h want %b/%h", i, c,
                                 res32[2*i+c].cout, res32[2*i+c].sum, i == 31, es);
                    end
                end
        end
    endtask

    task automatic test_carry_chain;
        res32.delete();
        push(32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 1'b0);
        run(100, 1'b1, "carry");
        checks++;
        if (res32.size() != 1 || res32[0].sum !== 32'h0 || res32[0].cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_chain: got n=%0d want 1/00000000", res32.size());
        end
    endtask

    task automatic test_subtract;
        res32.delete();
        push(32'd5, 32'd7, 1'b0, 1'b1);
        push(32'd7, 32'd5, 1'b0, 1'b1);
        run(100, 1'b1, "sub");
        checks++;
        if (res32.size() != 2 || res32[0].sum !== 32'hFFFF_FFFE || res32[0].cout !== 1'b0 ||
            res32[1].sum !== 32'd2 || res32[1].cout !== 1'b1) begin
            errors++;
            $display("FAIL subtract: got n=%0d want FFFFFFFE/0 then 2/1", res32.size());
        end
    endtask

    task automatic test_back_to_back;
        res32.delete();
        for (int i = 0; i < 20; i++) push($urandom, $urandom, 1'($urandom), 1'($urandom));
        run(50, 1'b0, "bp");
        checks++;
        if (res32.size() != 20) begin
            errors++;
            $display("FAIL bp_count: got %0d want 20", res32.size());
        end
    endtask

`ifdef ADDER_PIPE_OVF_EN
    task automatic test_ovf;
        res32.delete();
        push(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        push(32'h8000_0000, 32'd1, 1'b0, 1'b1);
        push(32'd1, 32'd1, 1'b0, 1'b0);
        run(100, 1'b1, "ovf");
        checks++;
        if (res32.size() != 3 || res32[0].ovf !== 1'b1 || res32[1].ovf !== 1'b1 ||
            res32[2].ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_cases: got n=%0d want ovf 1,1,0", res32.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_walking();
        test_carry_chain();
        test_subtract();
        test_back_to_back();
`ifdef ADDER_PIPE_OVF_EN
        test_ovf();
`endif
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
